enemy_control: RTL and testbench

- Per-frame sequencer that drives the enemy block's phase strobes: init, idle, gen_move, move_enemies and draw_enemies.
- Consumes the enemy block's draw_done and a frame tick from the VGA timing side.
- Sits directly upstream of the enemy stage.
- Throttles movement with frame dividers, gives the collision detector settle time before a move is committed, and recovers from a hung draw with a timeout.

---
 rtl/enemy_control.sv | 108 ++++++++++
 tb/tb_enemy_control.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_control.sv
// enemy_control: per-frame sequencer driving the enemy block's init/idle/gen/move/draw phases.
// Strobes are registered state decodes, one cycle after their cause; no backpressure, ticks outside IDLE are dropped.
module enemy_control #(
  parameter int MOVE_DIV     = 2,
  parameter int GEN_DIV      = 8,
  parameter int SETTLE       = 2,
  parameter int DRAW_TIMEOUT = 300
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       draw_done,
  output logic       init,
  output logic       idle,
  output logic       gen_move,
  output logic       move_enemies,
  output logic       draw_enemies,
  output logic [7:0] frame_count,
  output logic       timeout_err
);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_GEN   = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_MOVE  = 3'd5;
  localparam logic [2:0] S_DRAW  = 3'd6;

  localparam int          DW          = $clog2(DRAW_TIMEOUT + 1);
  localparam logic [3:0]  MOVE_LAST   = 4'(MOVE_DIV - 1);
  localparam logic [3:0]  GEN_LAST    = 4'(GEN_DIV - 1);
  localparam logic [2:0]  SETTLE_LAST = 3'(SETTLE - 1);
  localparam logic [DW-1:0] DRAW_LAST = DW'(DRAW_TIMEOUT - 1);

  logic [2:0]    state, state_nxt;
  logic [3:0]    move_cnt, gen_cnt;
  logic [2:0]    settle_cnt;
  logic [DW-1:0] draw_cnt;
  logic          idle_min;
  logic          tick_ok, move_frame, gen_frame, draw_expired;

  always_comb begin
    state_nxt    = state;
    tick_ok      = (state == S_IDLE) && idle_min && frame_tick;
    move_frame   = (move_cnt == MOVE_LAST);
    gen_frame    = (gen_cnt == GEN_LAST);
    draw_expired = (draw_cnt == DRAW_LAST) && !draw_done;
    case (state)
      S_BOOT:  if (start) state_nxt = S_INIT;
      S_INIT:  state_nxt = S_IDLE;
      S_IDLE: begin
        if (tick_ok) begin
          if (!move_frame)    state_nxt = S_DRAW;
          else if (gen_frame) state_nxt = S_GEN;
          else                state_nxt = S_CHECK;
        end
      end
      S_GEN:   state_nxt = S_CHECK;
      S_CHECK: if (settle_cnt == SETTLE_LAST) state_nxt = S_MOVE;
      S_MOVE:  state_nxt = S_DRAW;
      S_DRAW:  if (draw_done || draw_expired) state_nxt = S_IDLE;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_BOOT;
      move_cnt    <= 4'd0;
      gen_cnt     <= 4'd0;
      settle_cnt  <= 3'd0;
      draw_cnt    <= '0;
      idle_min    <= 1'b0;
      frame_count <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      // Low on the first IDLE cycle so a lingering draw_done/tick is not taken as a new frame.
      idle_min   <= (state == S_IDLE);
      settle_cnt <= (state == S_CHECK) ? settle_cnt + 3'd1 : 3'd0;
      draw_cnt   <= (state == S_DRAW) ? draw_cnt + DW'(1) : '0;
      if (state == S_INIT) begin
        frame_count <= 8'd0;
        move_cnt    <= MOVE_LAST;
        gen_cnt     <= GEN_LAST;
        timeout_err <= 1'b0;
      end else if (tick_ok) begin
        frame_count <= frame_count + 8'd1;
        if (move_frame) begin
          move_cnt <= 4'd0;
          gen_cnt  <= gen_frame ? 4'd0 : gen_cnt + 4'd1;
        end else begin
          move_cnt <= move_cnt + 4'd1;
        end
      end
      if ((state == S_DRAW) && draw_expired) timeout_err <= 1'b1;
    end
  end

  assign init         = (state == S_INIT);
  assign idle         = (state == S_IDLE);
  assign gen_move     = (state == S_GEN);
  assign move_enemies = (state == S_MOVE);
  assign draw_enemies = (state == S_DRAW);

endmodule

// File: tb/tb_enemy_control.sv
// Bench for enemy_control: frame-level reference model checked every cycle, plus literal latency/count checks.
module tb_enemy_control;
  localparam int MOVE_DIV = 2, GEN_DIV = 8, SETTLE = 2, DRAW_TIMEOUT = 300;

  logic clock = 1'b0, reset = 1'b0, start = 1'b0, frame_tick = 1'b0, draw_done = 1'b0;
  logic init, idle, gen_move, move_enemies, draw_enemies, timeout_err;
  logic [7:0] frame_count;

  enemy_control #(.MOVE_DIV(MOVE_DIV), .GEN_DIV(GEN_DIV), .SETTLE(SETTLE), .DRAW_TIMEOUT(DRAW_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start), .frame_tick(frame_tick), .draw_done(draw_done),
    .init(init), .idle(idle), .gen_move(gen_move), .move_enemies(move_enemies),
    .draw_enemies(draw_enemies), .frame_count(frame_count), .timeout_err(timeout_err));

  always #5 clock = ~clock;

  int n_checks = 0, n_fail = 0, n_gen = 0, n_move = 0;

  // Reference model: frames and moves counted from INIT; pre-draw phases kept as a strobe script.
  localparam int M_BOOT = 0, M_INIT = 1, M_IDLE = 2, M_SCRIPT = 3, M_DRAW = 4;
  int m_mode = M_BOOT, m_frames = 0, m_moves = 0, m_idle_age = 0, m_draw_age = 0, m_fc = 0;
  bit m_terr = 1'b0;
  int m_script[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  task automatic m_reset();
    m_mode = M_BOOT; m_fc = 0; m_terr = 1'b0; m_idle_age = 0; m_draw_age = 0;
    m_script.delete();
  endtask

  task automatic model_tick();
    if (!reset) begin
      m_reset();
      return;
    end
    case (m_mode)
      M_BOOT: if (start) m_mode = M_INIT;
      M_INIT: begin
        m_mode = M_IDLE; m_idle_age = 0; m_frames = 0; m_moves = 0; m_fc = 0; m_terr = 1'b0;
      end
      M_IDLE: begin
        if (m_idle_age >= 1 && frame_tick) begin
          m_frames++;
          m_fc = (m_fc + 1) % 256;
          if ((m_frames - 1) % MOVE_DIV == 0) begin
            m_moves++;
            if ((m_moves - 1) % GEN_DIV == 0) m_script.push_back(1);
            for (int i = 0; i < SETTLE; i++) m_script.push_back(0);
            m_script.push_back(2);
            m_mode = M_SCRIPT;
          end else begin
            m_mode = M_DRAW; m_draw_age = 0;
          end
        end else begin
          m_idle_age++;
        end
      end
      M_SCRIPT: begin
        void'(m_script.pop_front());
        if (m_script.size() == 0) begin m_mode = M_DRAW; m_draw_age = 0; end
      end
      M_DRAW: begin
        if (draw_done) begin
          m_mode = M_IDLE; m_idle_age = 0;
        end else if (m_draw_age == DRAW_TIMEOUT - 1) begin
          m_mode = M_IDLE; m_idle_age = 0; m_terr = 1'b1;
        end else begin
          m_draw_age++;
        end
      end
      default: m_mode = M_BOOT;
    endcase
  endtask

  task automatic compare_all();
    bit e_gen, e_move;
    e_gen  = (m_mode == M_SCRIPT) && (m_script.size() > 0) && (m_script[0] == 1);
    e_move = (m_mode == M_SCRIPT) && (m_script.size() > 0) && (m_script[0] == 2);
    chk("init", init, m_mode == M_INIT);
    chk("idle", idle, m_mode == M_IDLE);
    chk("gen_move", gen_move, e_gen);
    chk("move_enemies", move_enemies, e_move);
    chk("draw_enemies", draw_enemies, m_mode == M_DRAW);
    chk("frame_count", frame_count, m_fc);
    chk("timeout_err", timeout_err, m_terr);
    chk("onehot", $countones({init, idle, gen_move, move_enemies, draw_enemies}) <= 1, 1);
    n_gen  += (gen_move === 1'b1) ? 1 : 0;
    n_move += (move_enemies === 1'b1) ? 1 : 0;
  endtask

  task automatic step();
    @(negedge clock);
    compare_all();
    @(posedge clock);
    model_tick();
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (idle !== 1'b1) begin
      if (n >= lim) begin bound_fail("wait_idle"); return; end
      step(); n++;
    end
  endtask

  task automatic wait_draw(input int lim);
    int n = 0;
    while (draw_enemies !== 1'b1) begin
      if (n >= lim) begin bound_fail("wait_draw"); return; end
      step(); n++;
    end
  endtask

  task automatic run_frame(input int dly);
    wait_idle(20);
    step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    wait_draw(20);
    repeat (dly - 1) step();
    draw_done = 1'b1; step(); draw_done = 1'b0;
  endtask

  initial begin
    int n;
    m_reset();
    repeat (3) step();
    reset = 1'b1;
    repeat (10) step();
    chk("boot_strobes", {init, idle, gen_move, move_enemies, draw_enemies}, 0);
    chk("boot_fc", frame_count, 0);
    start = 1'b1; step();
    chk("init_pulse", init, 1);
    start = 1'b0; step();
    chk("init_gone", init, 0);
    chk("idle_after_init", idle, 1);
    chk("fc_after_init", frame_count, 0);

    // Frame 1: full move frame latency
    step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("lat_gen_t1", gen_move, 1);
    step(); chk("lat_check_t2", {gen_move, move_enemies, draw_enemies}, 0);
    step(); chk("lat_check_t3", move_enemies, 0);
    step(); chk("lat_move_t4", move_enemies, 1);
    step(); chk("lat_draw_t5", draw_enemies, 1);
    repeat (255) step();
    chk("draw_held_256", draw_enemies, 1);
    draw_done = 1'b1; step();
    chk("idle_after_done", idle, 1);
    chk("fc_frame1", frame_count, 1);
    // Tick on the first IDLE cycle with draw_done still high must be ignored
    frame_tick = 1'b1; step();
    chk("tick_ignored_idle", idle, 1);
    chk("tick_ignored_fc", frame_count, 1);
    draw_done = 1'b0; step(); frame_tick = 1'b0;
    chk("tick2_draw", draw_enemies, 1);
    chk("tick2_fc", frame_count, 2);
    draw_done = 1'b1; step(); draw_done = 1'b0;

    for (int f = 3; f <= 16; f++) run_frame(256);
    wait_idle(20);
    chk("moves_16", n_move, 8);
    chk("gens_16", n_gen, 1);
    chk("fc_16", frame_count, 16);
    run_frame(3);
    wait_idle(20);
    chk("gens_17", n_gen, 2);
    chk("moves_17", n_move, 9);
    chk("fc_17", frame_count, 17);

    // Frame 18: draw never completes
    step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    wait_draw(20);
    n = 0;
    while (draw_enemies === 1'b1 && n < 400) begin step(); n++; end
    chk("timeout_len", n, DRAW_TIMEOUT);
    chk("timeout_idle", idle, 1);
    chk("timeout_err_set", timeout_err, 1);

    // Frame 19 is a move frame without a pick: reset lands in CHECK
    step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("in_check", {init, idle, gen_move, move_enemies, draw_enemies}, 0);
    reset = 1'b0; m_reset(); #1;
    chk("rst_strobes", {init, idle, gen_move, move_enemies, draw_enemies}, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_terr", timeout_err, 0);
    step();
    reset = 1'b1; start = 1'b1; step();
    chk("reinit", init, 1);
    chk("reinit_terr", timeout_err, 0);
    start = 1'b0; step();

    // 256 quick frames with draw_done held high
    draw_done = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wait_idle(50);
      if (i == 255) chk("fc_255", frame_count, 255);
      step();
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
    end
    wait_idle(50);
    chk("fc_wrap", frame_count, 0);
    draw_done = 1'b0;

    for (int c = 0; c < 4000; c++) begin
      frame_tick = ($urandom_range(0, 3) == 0);
      draw_done  = ($urandom_range(0, 11) == 0);
      start      = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 799) == 0) begin
        reset = 1'b0; m_reset();
      end else begin
        reset = 1'b1;
      end
      step();
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
